// File: rtl/dds_seq_pkg.sv
// dds_seq_pkg: shared types and constants for the DDS tone sequencer.
// Holds the FSM state encoding, the cfg_data field layout and the
// duration decoding rule (a programmed duration of 0 means 256 clocks).
package dds_seq_pkg;

   // Sequencer FSM states
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Layout of one segment-table word
   localparam int CFG_W    = 16;
   localparam int PINC_MSB = 15;
   localparam int PINC_LSB = 8;
   localparam int DUR_MSB  = 7;
   localparam int DUR_LSB  = 0;

   // Duration field width and the counter width needed to hold 256
   localparam int DUR_W = DUR_MSB - DUR_LSB + 1;
   localparam int CNT_W = DUR_W + 1;

   // Length used when the programmed duration is zero
   localparam logic [CNT_W-1:0] DUR_ZERO_LEN = 9'd256;

   // Convert a raw duration field into a cycle count (1..256)
   function automatic logic [CNT_W-1:0] dur_decode(input logic [DUR_W-1:0] i_dur);
      logic [CNT_W-1:0] w_len;
      if (i_dur == 8'd0) begin
         w_len = DUR_ZERO_LEN;
      end else begin
         w_len = {1'b0, i_dur};
      end
      return w_len;
   endfunction

endpackage

// File: rtl/dds_seq_table.sv
// dds_seq_table: DEPTH x 16 segment register file.
// One synchronous write port and one asynchronous read port, so a word
// written on one edge is readable combinationally in the following cycle.
// Contents are deliberately not reset; software programs them before use.
module dds_seq_table
   import dds_seq_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [CFG_W-1:0] i_wdata,
   input  logic [AW-1:0]    i_raddr,
   output logic [CFG_W-1:0] o_rdata
);

   logic [CFG_W-1:0] r_mem [DEPTH];

   // Store a segment word when the write port is enabled
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dds_tone_sequencer.sv
// dds_tone_sequencer: steps the DDS through a programmed list of tone
// segments (phase increment + duration), driving phase_inc/dds_en
// cycle-accurately and reporting progress.
// Optional feature macro: DDS_SEQ_LOOP_EN -- when defined, a sequence
// started with loop=1 wraps from the last segment back to segment 0 with
// no gap and only ends on stop or reset. When undefined, loop is ignored.
module dds_tone_sequencer
   import dds_seq_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [AW-1:0]    cfg_addr,
   input  logic [CFG_W-1:0] cfg_data,
   input  logic [AW:0]      n_seg,
   input  logic             start,
   input  logic             stop,
   input  logic             loop,
   output logic [7:0]       phase_inc,
   output logic             dds_en,
   output logic [AW-1:0]    seg_idx,
   output logic             seg_start,
   output logic             busy,
   output logic             done
);

   // FSM state
   state_t           r_state;
   state_t           w_state_nxt;

   // Sequencing registers and their next values
   logic [AW-1:0]    r_idx;
   logic [AW-1:0]    w_idx_nxt;
   logic [AW-1:0]    r_last;
   logic [AW-1:0]    w_last_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;

   // Registered outputs and their next values
   logic [7:0]       r_phase_inc;
   logic [7:0]       w_phase_nxt;
   logic             r_dds_en;
   logic             w_dds_en_nxt;
   logic             r_seg_start;
   logic             w_seg_start_nxt;
   logic             r_busy;
   logic             w_busy_nxt;
   logic             r_done;
   logic             w_done_nxt;

   // Table access
   logic             w_wr_en;
   logic [AW-1:0]    w_rd_addr;
   logic [CFG_W-1:0] w_rd_data;
   logic [7:0]       w_rd_pinc;
   logic [DUR_W-1:0] w_rd_dur;

   // Start qualification and loop control
   logic             w_start_acc;
   logic [AW-1:0]    w_start_last;
   logic             w_loop_act;

   // The table is only writable while no sequence is playing
   assign cfg_ready = (r_state == IDLE);
   assign w_wr_en   = cfg_valid && (r_state == IDLE);

   assign w_start_acc = (r_state == IDLE) && start && !stop && (n_seg != '0);

   assign w_rd_pinc = w_rd_data[PINC_MSB:PINC_LSB];
   assign w_rd_dur  = w_rd_data[DUR_MSB:DUR_LSB];

   dds_seq_table #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_table (
      .clk     (clk),
      .i_we    (w_wr_en),
      .i_waddr (cfg_addr),
      .i_wdata (cfg_data),
      .i_raddr (w_rd_addr),
      .o_rdata (w_rd_data)
   );

`ifdef DDS_SEQ_LOOP_EN
   logic r_loop;

   // Capture the loop request together with each accepted start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_loop <= 1'b0;
      end else if (w_start_acc) begin
         r_loop <= loop;
      end else begin
         r_loop <= r_loop;
      end
   end

   assign w_loop_act = r_loop;
`else
   logic w_unused_loop;
   assign w_unused_loop = loop;
   assign w_loop_act    = 1'b0;
`endif

   // Index of the last segment to play: n_seg - 1, clamped to the table size
   always_comb begin
      if (n_seg > (AW+1)'(DEPTH)) begin
         w_start_last = AW'(DEPTH - 1);
      end else begin
         w_start_last = n_seg[AW-1:0] - AW'(1);
      end
   end

   // Read address always points at the segment that would be loaded next
   always_comb begin
      w_rd_addr = '0;
      case (r_state)
         IDLE: begin
            w_rd_addr = '0;
         end
         RUN: begin
            if (r_idx == r_last) begin
               w_rd_addr = '0;
            end else begin
               w_rd_addr = r_idx + AW'(1);
            end
         end
         default: begin
            w_rd_addr = '0;
         end
      endcase
   end

   // Next-state and next-output logic; pulses default low, everything else holds
   always_comb begin
      w_state_nxt     = r_state;
      w_idx_nxt       = r_idx;
      w_last_nxt      = r_last;
      w_cnt_nxt       = r_cnt;
      w_phase_nxt     = r_phase_inc;
      w_dds_en_nxt    = r_dds_en;
      w_busy_nxt      = r_busy;
      w_seg_start_nxt = 1'b0;
      w_done_nxt      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_start_acc) begin
               w_state_nxt     = RUN;
               w_idx_nxt       = '0;
               w_last_nxt      = w_start_last;
               w_phase_nxt     = w_rd_pinc;
               w_cnt_nxt       = dur_decode(w_rd_dur);
               w_dds_en_nxt    = 1'b1;
               w_busy_nxt      = 1'b1;
               w_seg_start_nxt = 1'b1;
            end else begin
               w_idx_nxt    = '0;
               w_phase_nxt  = 8'd0;
               w_dds_en_nxt = 1'b0;
               w_busy_nxt   = 1'b0;
            end
         end
         RUN: begin
            if (stop) begin
               // Abort wins over segment expiry and never reports done
               w_state_nxt  = IDLE;
               w_idx_nxt    = '0;
               w_cnt_nxt    = '0;
               w_phase_nxt  = 8'd0;
               w_dds_en_nxt = 1'b0;
               w_busy_nxt   = 1'b0;
            end else if (r_cnt == CNT_W'(1)) begin
               if ((r_idx == r_last) && !w_loop_act) begin
                  w_state_nxt  = IDLE;
                  w_idx_nxt    = '0;
                  w_cnt_nxt    = '0;
                  w_phase_nxt  = 8'd0;
                  w_dds_en_nxt = 1'b0;
                  w_busy_nxt   = 1'b0;
                  w_done_nxt   = 1'b1;
               end else begin
                  // Seamless hand-over to the next (or wrapped) segment
                  w_idx_nxt       = w_rd_addr;
                  w_phase_nxt     = w_rd_pinc;
                  w_cnt_nxt       = dur_decode(w_rd_dur);
                  w_seg_start_nxt = 1'b1;
               end
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt  = IDLE;
            w_idx_nxt    = '0;
            w_cnt_nxt    = '0;
            w_phase_nxt  = 8'd0;
            w_dds_en_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Sequencing counters and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx       <= '0;
         r_last      <= '0;
         r_cnt       <= '0;
         r_phase_inc <= 8'd0;
         r_dds_en    <= 1'b0;
         r_seg_start <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_idx       <= w_idx_nxt;
         r_last      <= w_last_nxt;
         r_cnt       <= w_cnt_nxt;
         r_phase_inc <= w_phase_nxt;
         r_dds_en    <= w_dds_en_nxt;
         r_seg_start <= w_seg_start_nxt;
         r_busy      <= w_busy_nxt;
         r_done      <= w_done_nxt;
      end
   end

   assign phase_inc = r_phase_inc;
   assign dds_en    = r_dds_en;
   assign seg_idx   = r_idx;
   assign seg_start = r_seg_start;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule

// File: tb/tb_dds_tone_sequencer.sv
// tb_dds_tone_sequencer: scoreboard bench. Expected per-cycle output words
// are expanded from a shadow copy of the segment table and queued when a
// sequence is launched; one word is popped and compared every cycle.
// Word layout: {cfg_ready, busy, dds_en, seg_start, done, seg_idx[2:0], phase_inc[7:0]}.
module tb_dds_tone_sequencer;

   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b1;
   logic          cfg_valid = 1'b0;
   logic          cfg_ready;
   logic [AW-1:0] cfg_addr  = '0;
   logic [15:0]   cfg_data  = 16'd0;
   logic [AW:0]   n_seg     = '0;
   logic          start     = 1'b0;
   logic          stop      = 1'b0;
   logic          loop      = 1'b0;
   logic [7:0]    phase_inc;
   logic          dds_en;
   logic [AW-1:0] seg_idx;
   logic          seg_start;
   logic          busy;
   logic          done;

   int            n_checks = 0;
   int            n_errors = 0;
   logic [15:0]   sb_q[$];
   logic [7:0]    sh_pinc [DEPTH];
   logic [7:0]    sh_dur  [DEPTH];

   dds_tone_sequencer #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data),
      .n_seg     (n_seg),
      .start     (start),
      .stop      (stop),
      .loop      (loop),
      .phase_inc (phase_inc),
      .dds_en    (dds_en),
      .seg_idx   (seg_idx),
      .seg_start (seg_start),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mk(input logic cr, input logic bs, input logic en,
                                      input logic ss, input logic dn,
                                      input logic [AW-1:0] idx, input logic [7:0] pi);
      return {cr, bs, en, ss, dn, idx, pi};
   endfunction

   function automatic logic [15:0] obs_word();
      return {cfg_ready, busy, dds_en, seg_start, done, seg_idx, phase_inc};
   endfunction

   task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Expected cycles of segments 0..n-1 from the shadow table
   task automatic push_segs(input int n);
      for (int k = 0; k < n; k++) begin
         int d;
         d = (sh_dur[k] == 8'd0) ? 256 : int'(sh_dur[k]);
         for (int c = 0; c < d; c++) begin
            sb_q.push_back(mk(1'b0, 1'b1, 1'b1, (c == 0), 1'b0, AW'(k), sh_pinc[k]));
         end
      end
   endtask

   task automatic push_done();
      sb_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0, 8'd0));
   endtask

   task automatic push_idle(input int n);
      for (int i = 0; i < n; i++) begin
         sb_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 8'd0));
      end
   endtask

   // Program one table entry (called at a negedge while idle)
   task automatic write_entry(input int addr, input logic [7:0] pi, input logic [7:0] dur);
      cfg_valid = 1'b1;
      cfg_addr  = AW'(addr);
      cfg_data  = {pi, dur};
      check_eq("cfg_ready_idle", {15'd0, cfg_ready}, 16'd1);
      @(negedge clk);
      cfg_valid    = 1'b0;
      sh_pinc[addr] = pi;
      sh_dur[addr]  = dur;
   endtask

   // Optionally launch a sequence, then compare one queued word per cycle.
   // stop_cyc / wr_cyc / restart_cyc raise stop / a write / start after that cycle's compare.
   task automatic play(input string tag, input bit do_start, input int n_req, input bit with_stop,
                       input bit lp, input int stop_cyc, input int wr_cyc, input int restart_cyc);
      int cyc;
      cyc   = 0;
      n_seg = (AW+1)'(n_req);
      loop  = lp;
      start = do_start;
      stop  = with_stop;
      while (sb_q.size() > 0) begin
         @(negedge clk);
         cyc++;
         start     = 1'b0;
         stop      = 1'b0;
         cfg_valid = 1'b0;
         check_eq($sformatf("%s[%0d]", tag, cyc), obs_word(), sb_q.pop_front());
         if (cyc == stop_cyc) stop = 1'b1;
         if (cyc == restart_cyc) start = 1'b1;
         if (cyc == wr_cyc) begin
            cfg_valid = 1'b1;
            cfg_addr  = '0;
            cfg_data  = 16'hFFFF;
         end
      end
      start     = 1'b0;
      stop      = 1'b0;
      cfg_valid = 1'b0;
      loop      = 1'b0;
   endtask

   initial begin
      // Reset state
      #2 rst_n = 1'b0;
      @(negedge clk);
      check_eq("reset", obs_word(), mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 8'd0));
      @(negedge clk);
      rst_n = 1'b1;
      push_idle(3);
      play("idle_after_reset", 1'b0, 0, 1'b0, 1'b0, 0, 0, 0);

      // Basic three-segment sequence, write then start on the next cycle
      write_entry(0, 8'h10, 8'd3);
      write_entry(1, 8'h20, 8'd1);
      write_entry(2, 8'h05, 8'd2);
      push_segs(3); push_done(); push_idle(1);
      play("basic", 1'b1, 3, 1'b0, 1'b0, 0, 0, 0);

      // Back-to-back: new start accepted during the done cycle
      push_segs(3); push_done(); push_segs(3); push_done(); push_idle(1);
      play("b2b", 1'b1, 3, 1'b0, 1'b0, 0, 0, 7);

      // Duration 0 means 256 cycles
      write_entry(0, 8'h7F, 8'd0);
      push_segs(1); push_done(); push_idle(1);
      play("dur0", 1'b1, 1, 1'b0, 1'b0, 0, 0, 0);

      // Abort on cycle 2 of segment 1, write attempted during RUN
      write_entry(0, 8'h11, 8'd2);
      write_entry(1, 8'h22, 8'd4);
      push_segs(1);
      sb_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, AW'(1), 8'h22));
      sb_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, AW'(1), 8'h22));
      push_idle(2);
      play("abort", 1'b1, 2, 1'b0, 1'b0, 4, 1, 0);

      // Readback: entry 0 must be unchanged by the rejected write
      push_segs(1); push_done(); push_idle(1);
      play("readback", 1'b1, 1, 1'b0, 1'b0, 0, 0, 0);

      // Stop on the final cycle of the last segment beats expiry: no done
      push_segs(1); push_idle(2);
      play("stop_vs_expiry", 1'b1, 1, 1'b0, 1'b0, 2, 0, 0);

      // Boundaries: n_seg=0 and start+stop together are ignored
      push_idle(3);
      play("nseg0", 1'b1, 0, 1'b0, 1'b0, 0, 0, 0);
      push_idle(3);
      play("start_stop", 1'b1, 1, 1'b1, 1'b0, 0, 0, 0);

      // n_seg = DEPTH+1 plays DEPTH segments
      for (int i = 0; i < DEPTH; i++) begin
         write_entry(i, 8'h80 + 8'(i), (i == 5) ? 8'd0 : 8'(i + 1));
      end
      push_segs(DEPTH); push_done(); push_idle(1);
      play("clamp", 1'b1, DEPTH + 1, 1'b0, 1'b0, 0, 0, 0);

      // Loop request with two 2-cycle segments
      write_entry(0, 8'h31, 8'd2);
      write_entry(1, 8'h42, 8'd2);
`ifdef DDS_SEQ_LOOP_EN
      for (int p = 0; p < 4; p++) push_segs(2);
      push_idle(2);
      play("loop", 1'b1, 2, 1'b0, 1'b1, 16, 0, 0);
`else
      push_segs(2); push_done(); push_idle(1);
      play("loop_ignored", 1'b1, 2, 1'b0, 1'b1, 0, 0, 0);
`endif

      // Asynchronous reset in the middle of a sequence
      n_seg = (AW+1)'(2);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_eq("pre_async_rst", obs_word(), mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0, 8'h31));
      #2 rst_n = 1'b0;
      #1 check_eq("async_rst", obs_word(), mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 8'd0));
      @(negedge clk);
      rst_n = 1'b1;
      push_idle(2);
      play("post_async_rst", 1'b0, 0, 1'b0, 1'b0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dds_tone_sequencer.md
# dds_tone_sequencer

Controller that schedules the on-chip DDS through a programmed list of tone segments, each with a phase increment and a duration. The block sits between the configuration interface and the DDS phase-accumulator/sine-LUT datapath. It drives the DDS `phase_inc` and `dds_en` inputs cycle-accurately and reports sequence progress to the top level. It contains no sine datapath of its own.

## Interface
Parameters:
- `DEPTH`, 8: number of segment-table entries (power of two, 2..16)
- `AW`, 3: table address width, equal to log2(DEPTH)

Ports:
- `clk`  in  1: single system clock; all logic on rising edge
- `rst_n`  in  1: reset, asynchronous, active-low
- `cfg_valid`  in  1: table write request
- `cfg_ready`  out  1: table write accepted when high with `cfg_valid`
- `cfg_addr`  in  AW: table entry index
- `cfg_data`  in  16: [15:8] phase increment, [7:0] duration in clocks (0 means 256)
- `n_seg`  in  AW+1: number of segments to play, sampled on accepted `start`
- `start`  in  1: level-sampled start request
- `stop`  in  1: abort request
- `loop`  in  1: repeat sequence (see Configuration)
- `phase_inc`  out  8: phase increment to the DDS
- `dds_en`  out  1: DDS accumulator enable
- `seg_idx`  out  AW: index of the segment currently playing
- `seg_start`  out  1: one-cycle pulse on the first cycle of each segment
- `busy`  out  1: high in RUN
- `done`  out  1: one-cycle pulse on normal completion

## Operation
- FSM has two states, IDLE and RUN. Reset value is IDLE.
- Reset values: `phase_inc`=0, `dds_en`=0, `seg_idx`=0, `seg_start`=0, `busy`=0, `done`=0, `cfg_ready`=1. Table contents are not reset.
- `cfg_ready` = !`busy`. A write occurs on `cfg_valid && cfg_ready`. Writes in RUN are not accepted and the table is unchanged.
- IDLE → RUN on `start && !stop && n_seg!=0`. `n_seg` is latched and clamped to DEPTH. A `start` with `n_seg`=0 is ignored.
- In RUN, segment k loads `phase_inc`=entry[k][15:8] and a down-counter = entry[k][7:0] (0 loads 256). `dds_en`=1 throughout.
- When the counter expires on segment k < n_seg-1, segment k+1 begins on the next cycle with no gap.
- When the counter expires on the last segment, the FSM returns to IDLE. `done` pulses, `dds_en`→0, `phase_inc`→0, `seg_idx`→0.
- `stop` in RUN: IDLE on the next edge, outputs return to reset values, and no `done`. `stop` has priority over counter expiry in the same cycle.
- `start` in RUN is ignored.
- Reset asserted mid-sequence forces reset values immediately (asynchronous).

## Timing
- `start` sampled at edge N: at edge N+1, `busy`=1, `dds_en`=1, `phase_inc`=entry[0], `seg_start`=1.
- A segment of duration D holds its `phase_inc` for exactly D cycles.
- Total RUN time is the sum of segment durations. `done` is asserted in the first cycle after the last segment. `busy` is low in that same cycle.
- A new `start` is accepted in the same cycle `done` is high, so back-to-back sequences have a 1-cycle gap.
- A table write at edge N is visible to a `start` sampled at edge N+1.
- All outputs are registered. There is no combinational path from inputs to outputs except `cfg_ready` from state.

## Configuration
- Macro `DDS_SEQ_LOOP_EN`.
- Defined: with `loop`=1 (sampled at start), the last segment is followed directly by segment 0 with no gap. `seg_start` pulses, `done` does not, and only `stop` or reset ends the sequence.
- Undefined: the `loop` port exists but is ignored, and every sequence ends with `done`.

## Structure
- Package `dds_seq_pkg` holds:
  - the state enum (IDLE, RUN)
  - the field positions of `cfg_data` (`PINC_MSB`/`PINC_LSB`, `DUR_MSB`/`DUR_LSB`)
  - the duration width constant and the 256-on-zero rule constant
- One sub-module, `dds_seq_table`: DEPTH×16 register file with one synchronous write port and one asynchronous read port. The FSM, counter and output registers live in the top module.

## Test plan
- Reset: hold `rst_n`=0 → all outputs at reset values, `cfg_ready`=1. Release, no start → outputs unchanged.
- Program entries {0x10,3},{0x20,1},{0x05,2}, `n_seg`=3, pulse `start` → `phase_inc` 0x10,0x10,0x10,0x20,0x05,0x05, then `done` pulse. `seg_start` at cycles 1,4,5. `busy` high for 6 cycles.
- Duration 0: entry {0x7F,0}, `n_seg`=1 → `phase_inc`=0x7F for 256 cycles, then `done`.
- Abort: `stop` on cycle 2 of segment 1 → next cycle IDLE, `dds_en`=0, no `done`. A write during RUN is rejected (`cfg_ready`=0, table unchanged on readback run).
- Boundary: `start` with `n_seg`=0 → stays IDLE. `start`+`stop` same cycle → stays IDLE. `n_seg`=DEPTH+1 → plays DEPTH segments.
- Loop (`DDS_SEQ_LOOP_EN` defined, `loop`=1, 2 segments of 2) → pattern repeats seamlessly for ≥3 periods with no `done`. `stop` ends it. Without the macro, the same stimulus → `done` after 4 cycles.
